// File: rtl/video_pkg.sv
// Shared scan-timing types and default VGA 640x480 timing constants.
package video_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } scan_state_t;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_CW       = 10;

  // Total period of one axis: active + front porch + sync + back porch.
  function automatic int unsigned scan_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/scan_counter.sv
// Wrapping counter: counts 0..MAX on inc, clr forces zero, wrap flags the MAX->0 step.
module scan_counter #(
  parameter int unsigned CW  = 10,
  parameter int unsigned MAX = 799
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          wrap
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Kept apart from the next-value logic so wrap never depends on clr.
  assign wrap = inc && (cnt_q == CW'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr || wrap) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pixel_scan_ctrl.sv
// Scan-timing controller: gates the pixel divider, advances H/V counters per strobe,
// and decodes sync, blanking and coordinate outputs with start/drain/restart control.
module pixel_scan_ctrl
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned CW       = DEF_CW
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          start,
  input  logic          stop,
  input  logic          pixel_tick,
  output logic          div_enable,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          busy
);

  localparam int unsigned H_TOTAL = scan_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = scan_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = VS_BEG + V_SYNC;

  scan_state_t   state_q, state_d;
  logic          busy_q, busy_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          cnt_inc;
  logic          cnt_clr;
  logic          h_wrap;
  logic          v_wrap;
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;

  // Ticks only advance the scan once running; a tick during launch is dropped.
  assign cnt_inc = (state_q != IDLE) && pixel_tick;

  scan_counter #(
    .CW  (CW),
    .MAX (H_TOTAL - 1)
  ) u_h_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .cnt   (h_cnt),
    .wrap  (h_wrap)
  );

  scan_counter #(
    .CW  (CW),
    .MAX (V_TOTAL - 1)
  ) u_v_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (h_wrap),
    .clr   (cnt_clr),
    .cnt   (v_cnt),
    .wrap  (v_wrap)
  );

  always_comb begin
    state_d       = state_q;
    cnt_clr       = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_clr = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (start) begin
          state_d = RUN;
        end else if (v_wrap) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    // Wraps announce a new line/frame only if scanning carries on past them.
    line_start_d  = ((state_q == IDLE) && start) || (h_wrap && busy_d);
    frame_start_d = ((state_q == IDLE) && start) || (v_wrap && busy_d);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign busy        = busy_q;
  assign div_enable  = busy_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign x           = h_cnt;
  assign y           = v_cnt;
  assign hsync  = ~(busy_q && (32'(h_cnt) >= HS_BEG) && (32'(h_cnt) < HS_END));
  assign vsync  = ~(busy_q && (32'(v_cnt) >= VS_BEG) && (32'(v_cnt) < VS_END));
  assign active = busy_q && (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);

endmodule

// File: tb/tb_pixel_scan_ctrl.sv
// Directed bench for pixel_scan_ctrl using 8x6 timing (H 4/1/2/1, V 3/1/1/1, CW=4).
module tb_pixel_scan_ctrl;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       start;
  logic       stop;
  logic       pixel_tick;
  logic       div_enable;
  logic       hsync;
  logic       vsync;
  logic       active;
  logic [3:0] x;
  logic [3:0] y;
  logic       line_start;
  logic       frame_start;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int ls_cnt   = 0;
  int fs_cnt   = 0;

  pixel_scan_ctrl #(
    .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .CW       (4)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start),
    .stop        (stop),
    .pixel_tick  (pixel_tick),
    .div_enable  (div_enable),
    .hsync       (hsync),
    .vsync       (vsync),
    .active      (active),
    .x           (x),
    .y           (y),
    .line_start  (line_start),
    .frame_start (frame_start),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to the next falling edge and tally the single-cycle pulses seen there.
  task automatic step();
    @(negedge clk);
    if (line_start)  ls_cnt++;
    if (frame_start) fs_cnt++;
  endtask

  task automatic tick();
    pixel_tick = 1'b1;
    step();
    pixel_tick = 1'b0;
    repeat (3) step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0; start = 1'b0; stop = 1'b0; pixel_tick = 1'b0;
    step(); step();
    check_eq("rst_busy",   busy,        0);
    check_eq("rst_diven",  div_enable,  0);
    check_eq("rst_hsync",  hsync,       1);
    check_eq("rst_vsync",  vsync,       1);
    check_eq("rst_active", active,      0);
    check_eq("rst_x",      x,           0);
    check_eq("rst_y",      y,           0);
    check_eq("rst_ls",     line_start,  0);
    check_eq("rst_fs",     frame_start, 0);
    n_rst = 1'b1;

    // Idle: ticks and stop are ignored
    stop = 1'b1;
    ticks(3);
    stop = 1'b0;
    check_eq("idle_busy",  busy,       0);
    check_eq("idle_diven", div_enable, 0);
    check_eq("idle_x",     x,          0);
    check_eq("idle_hsync", hsync,      1);
    check_eq("idle_pulses", ls_cnt + fs_cnt, 0);

    // Start with a coincident tick: the tick must not count
    start = 1'b1; pixel_tick = 1'b1;
    step();
    start = 1'b0; pixel_tick = 1'b0;
    check_eq("start_busy",  busy,        1);
    check_eq("start_diven", div_enable,  1);
    check_eq("start_fs",    frame_start, 1);
    check_eq("start_ls",    line_start,  1);
    check_eq("start_x",     x,           0);
    step();
    check_eq("start_fs_drop", frame_start, 0);
    check_eq("start_ls_drop", line_start,  0);
    step(); step();

    // One full frame, every position checked
    ls_cnt = 0; fs_cnt = 0;
    for (int yy = 0; yy < 6; yy++) begin
      for (int xx = 0; xx < 8; xx++) begin
        check_eq("frm_x",      x,      xx);
        check_eq("frm_y",      y,      yy);
        check_eq("frm_active", active, (xx < 4 && yy < 3) ? 1 : 0);
        check_eq("frm_hsync",  hsync,  (xx == 5 || xx == 6) ? 0 : 1);
        check_eq("frm_vsync",  vsync,  (yy == 4) ? 0 : 1);
        if (xx == 7 && yy == 5) check_eq("frm_fs_early", fs_cnt, 0);
        tick();
      end
    end
    check_eq("frm_wrap_x", x,      0);
    check_eq("frm_wrap_y", y,      0);
    check_eq("frm_ls_cnt", ls_cnt, 6);
    check_eq("frm_fs_cnt", fs_cnt, 1);
    check_eq("frm_busy",   busy,   1);

    // Stop at (2,1): drain the frame, then idle
    ticks(10);
    check_eq("stop_at_x", x, 2);
    check_eq("stop_at_y", y, 1);
    pulse_stop();
    check_eq("drain_busy", busy, 1);
    ticks(37);
    check_eq("drain_end_x",    x,    7);
    check_eq("drain_end_y",    y,    5);
    check_eq("drain_end_busy", busy, 1);
    ls_cnt = 0; fs_cnt = 0;
    tick();
    check_eq("drained_busy",  busy,       0);
    check_eq("drained_diven", div_enable, 0);
    check_eq("drained_x",     x,          0);
    check_eq("drained_y",     y,          0);
    check_eq("drained_fs",    fs_cnt,     0);
    check_eq("drained_ls",    ls_cnt,     0);
    check_eq("drained_hsync", hsync,      1);
    ticks(3);
    check_eq("post_drain_busy", busy, 0);
    check_eq("post_drain_x",    x,    0);

    // Restart during drain at y=3
    pulse_start();
    check_eq("c1_busy", busy, 1);
    ticks(24);
    check_eq("c1_y", y, 3);
    pulse_stop();
    ticks(2);
    check_eq("c1_x", x, 2);
    fs_cnt = 0;
    pulse_start();
    check_eq("c1_restart_busy", busy,   1);
    check_eq("c1_restart_fs",   fs_cnt, 0);
    ticks(22);
    check_eq("c1_wrap_x",  x,      0);
    check_eq("c1_wrap_y",  y,      0);
    check_eq("c1_wrap_bs", busy,   1);
    check_eq("c1_wrap_fs", fs_cnt, 1);
    tick();
    check_eq("c1_cont_busy", busy, 1);
    check_eq("c1_cont_x",    x,    1);

    // start+stop together in RUN: stop wins, frame drains to idle
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check_eq("c2_busy", busy, 1);
    ticks(46);
    check_eq("c2_end_x",    x,    7);
    check_eq("c2_end_y",    y,    5);
    check_eq("c2_end_busy", busy, 1);
    fs_cnt = 0;
    tick();
    check_eq("c2_idle_busy", busy,   0);
    check_eq("c2_idle_fs",   fs_cnt, 0);

    // Asynchronous reset mid-line at x=5
    pulse_start();
    ticks(5);
    check_eq("ar_pre_x",     x,     5);
    check_eq("ar_pre_hsync", hsync, 0);
    #2 n_rst = 1'b0;
    #1;
    check_eq("ar_hsync", hsync,      1);
    check_eq("ar_x",     x,          0);
    check_eq("ar_y",     y,          0);
    check_eq("ar_diven", div_enable, 0);
    check_eq("ar_busy",  busy,       0);
    step();
    n_rst = 1'b1;
    ticks(3);
    check_eq("ar_post_busy",  busy,       0);
    check_eq("ar_post_diven", div_enable, 0);
    check_eq("ar_post_x",     x,          0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
